// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory between requesters A and B,
// with optional locked bursts and an optional zero-fill pass after reset.
module memory_port_arbiter #(
    parameter int DATAWIDTH      = 8,
    parameter int DATADEPTH      = 1024,
    parameter int ADDRESSWIDTH   = $clog2(DATADEPTH),
    parameter int MAX_BURST      = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic                    a_write,
    input  logic                    a_lock,
    input  logic [ADDRESSWIDTH-1:0] a_address,
    input  logic [DATAWIDTH-1:0]    a_data,
    output logic                    a_rsp_valid,
    output logic [DATAWIDTH-1:0]    a_rsp_data,

    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic                    b_write,
    input  logic                    b_lock,
    input  logic [ADDRESSWIDTH-1:0] b_address,
    input  logic [DATAWIDTH-1:0]    b_data,
    output logic                    b_rsp_valid,
    output logic [DATAWIDTH-1:0]    b_rsp_data,

    output logic                    mem_write_en,
    output logic [ADDRESSWIDTH-1:0] mem_address,
    output logic [DATAWIDTH-1:0]    mem_data_in,
    input  logic [DATAWIDTH-1:0]    mem_data_out,

    output logic                    init_done
);

    // state     | meaning
    // ST_CLEAR  | zero-filling memory, clients stalled
    // ST_ARB    | round-robin between A and B
    // ST_LOCKED | burst owner holds the memory for up to MAX_BURST cycles

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0]           BURST_LAST = CW'(MAX_BURST - 1);
    localparam logic [ADDRESSWIDTH-1:0] CLEAR_LAST = ADDRESSWIDTH'(DATADEPTH - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_ARB, ST_LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] clear_addr_q, clear_addr_d;
    logic [CW-1:0]           burst_cnt_q, burst_cnt_d;
    logic                    last_grant_q, last_grant_d;   // 0 = A, 1 = B
    logic                    owner_q, owner_d;             // 0 = A, 1 = B
    logic                    init_done_q, init_done_d;
    logic                    a_rsp_valid_q, b_rsp_valid_q;
    logic                    grant_a, grant_b;
    logic                    owner_lock;

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        burst_cnt_d  = burst_cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        init_done_d  = init_done_q;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        mem_write_en = 1'b0;
        mem_address  = '0;
        mem_data_in  = '0;
        owner_lock   = owner_q ? b_lock : a_lock;

        case (state_q)
            ST_CLEAR: begin
                mem_write_en = 1'b1;
                mem_address  = clear_addr_q;
                clear_addr_d = clear_addr_q + ADDRESSWIDTH'(1);
                if (clear_addr_q == CLEAR_LAST) begin
                    state_d      = ST_ARB;
                    init_done_d  = 1'b1;
                    clear_addr_d = '0;
                end
            end
            ST_ARB: begin
                // on a tie the port that did not win last time is served
                grant_a = a_valid && (!b_valid || last_grant_q);
                grant_b = b_valid && (!a_valid || !last_grant_q);
                if (grant_a || grant_b) begin
                    last_grant_d = grant_b;
                    if ((grant_b ? b_lock : a_lock) && (MAX_BURST > 1)) begin
                        state_d     = ST_LOCKED;
                        owner_d     = grant_b;
                        burst_cnt_d = CW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                grant_a = !owner_q && a_valid;
                grant_b = owner_q && b_valid;
                // idle owner cycles still count toward the burst limit
                if (!owner_lock || (burst_cnt_q == BURST_LAST)) begin
                    state_d     = ST_ARB;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
            end
            default: state_d = ST_ARB;
        endcase

        if (grant_a) begin
            mem_write_en = a_write;
            mem_address  = a_address;
            mem_data_in  = a_data;
        end else if (grant_b) begin
            mem_write_en = b_write;
            mem_address  = b_address;
            mem_data_in  = b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
            clear_addr_q  <= '0;
            burst_cnt_q   <= '0;
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            init_done_q   <= (CLEAR_ON_RESET == 0);
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clear_addr_q  <= clear_addr_d;
            burst_cnt_q   <= burst_cnt_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            init_done_q   <= init_done_d;
            a_rsp_valid_q <= grant_a && !a_write;
            b_rsp_valid_q <= grant_b && !b_write;
        end
    end

    assign a_ready     = grant_a;
    assign b_ready     = grant_b;
    assign a_rsp_valid = a_rsp_valid_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign a_rsp_data  = a_rsp_valid_q ? mem_data_out : '0;
    assign b_rsp_data  = b_rsp_valid_q ? mem_data_out : '0;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Testbench for memory_port_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a beat-counting reference model.
module tb_memory_port_arbiter;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int MB    = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_valid = 0, a_write = 0, a_lock = 0;
    logic [AW-1:0] a_address = '0;
    logic [DW-1:0] a_data = '0;
    logic          b_valid = 0, b_write = 0, b_lock = 0;
    logic [AW-1:0] b_address = '0;
    logic [DW-1:0] b_data = '0;
    logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid;
    logic [DW-1:0] a_rsp_data, b_rsp_data;
    logic          mem_write_en, init_done;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_port_arbiter #(
        .DATAWIDTH(DW), .DATADEPTH(DEPTH), .ADDRESSWIDTH(AW),
        .MAX_BURST(MB), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_lock(a_lock),
        .a_address(a_address), .a_data(a_data), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_lock(b_lock),
        .b_address(b_address), .b_data(b_data), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .mem_write_en(mem_write_en), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .init_done(init_done)
    );

    // the memory instance the arbiter drives
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_write_en) ram[mem_address] <= mem_data_in;
        mem_data_out <= ram[mem_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: words left to clear, burst owner and beats used, last winner,
    // expected memory contents and pending read data per port
    int            m_clear_left, m_owner, m_beats, m_last;
    bit            live = 0;
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pa, m_pb;
    logic [DW-1:0] m_pa_d, m_pb_d;

    always @(negedge clk) begin
        int            g;
        logic          we, lk;
        logic [AW-1:0] ad;
        logic [DW-1:0] dd;
        if (!reset_n) begin
            m_clear_left = DEPTH;
            m_owner = -1;
            m_beats = 0;
            m_last = 1;
            m_pa = 0;
            m_pb = 0;
            live = 1;
        end else if (live) begin
            g = -1; we = 0; ad = '0; dd = '0;
            if (m_clear_left > 0) begin
                we = 1;
                ad = AW'(DEPTH - m_clear_left);
            end else if (m_owner == 0) g = a_valid ? 0 : -1;
            else if (m_owner == 1) g = b_valid ? 1 : -1;
            else if (a_valid && b_valid) g = (m_last == 0) ? 1 : 0;
            else if (a_valid) g = 0;
            else if (b_valid) g = 1;
            if (g == 0) begin we = a_write; ad = a_address; dd = a_data; end
            else if (g == 1) begin we = b_write; ad = b_address; dd = b_data; end

            check("a_ready", a_ready, g == 0);
            check("b_ready", b_ready, g == 1);
            check("mem_write_en", mem_write_en, we);
            check("mem_address", mem_address, ad);
            check("mem_data_in", mem_data_in, dd);
            check("init_done", init_done, m_clear_left == 0);
            check("a_rsp_valid", a_rsp_valid, m_pa);
            check("b_rsp_valid", b_rsp_valid, m_pb);
            check("a_rsp_data", a_rsp_data, m_pa ? m_pa_d : '0);
            check("b_rsp_data", b_rsp_data, m_pb ? m_pb_d : '0);

            m_pa   = (g == 0) && !a_write;
            m_pb   = (g == 1) && !b_write;
            m_pa_d = m_mem[a_address];
            m_pb_d = m_mem[b_address];
            if (m_clear_left > 0) begin
                m_mem[ad] = '0;
                m_clear_left--;
            end else begin
                if (m_owner >= 0) begin
                    lk = (m_owner == 0) ? a_lock : b_lock;
                    if (!lk || m_beats == MB - 1) m_owner = -1;
                    else m_beats++;
                end else if (g >= 0 && ((g == 0) ? a_lock : b_lock) && MB > 1) begin
                    m_owner = g;
                    m_beats = 1;
                end
                if (g >= 0) begin
                    m_last = g;
                    if (we) m_mem[ad] = dd;
                end
            end
        end
    end

    task automatic drive(input bit av, input bit aw, input bit al, input int aa, input int ad,
                         input bit bv, input bit bw, input bit bl, input int ba, input int bd);
        @(posedge clk); #1;
        a_valid = av; a_write = aw; a_lock = al; a_address = AW'(aa); a_data = DW'(ad);
        b_valid = bv; b_write = bw; b_lock = bl; b_address = AW'(ba); b_data = DW'(bd);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        bit ha, hb;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        // zero-fill pass
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("clr_we", mem_write_en, 1);
            check("clr_addr", mem_address, i);
            check("clr_ready", {a_ready, b_ready}, 0);
            check("clr_init_low", init_done, 0);
        end
        @(negedge clk);
        check("init_done_rise", init_done, 1);

        drive(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("rd5_ready", a_ready, 1);
        idle();
        @(negedge clk); check("rd5_rsp_valid", a_rsp_valid, 1); check("rd5_rsp_data", a_rsp_data, 0);

        // write then read back on A
        drive(1, 1, 0, 3, 'hA5, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("wr3_ready", a_ready, 1); check("wr3_we", mem_write_en, 1);
        check("wr3_addr", mem_address, 3); check("wr3_data", mem_data_in, 'hA5);
        drive(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("rd3_ready", a_ready, 1); check("rd3_we", mem_write_en, 0);
        idle();
        @(negedge clk);
        check("rd3_rsp_valid", a_rsp_valid, 1); check("rd3_rsp_data", a_rsp_data, 'hA5);
        check("rd3_b_quiet", b_rsp_valid, 0);

        drive(0, 0, 0, 0, 0, 1, 1, 0, 7, 'h3C);
        @(negedge clk); check("wr7_ready", b_ready, 1);

        // plain round robin
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 3, 0, 1, 0, 0, 7, 0);
            @(negedge clk);
            check("rr_a_ready", a_ready, (i % 2) == 0);
            check("rr_b_ready", b_ready, (i % 2) == 1);
            if (i == 1) begin
                check("rr_a_rsp", a_rsp_data, 'hA5); check("rr_b_quiet", b_rsp_valid, 0);
            end
            if (i == 2) begin
                check("rr_b_rsp", b_rsp_data, 'h3C); check("rr_a_quiet", a_rsp_valid, 0);
            end
        end
        idle();
        @(negedge clk); check("rr_last_b_rsp", b_rsp_valid, 1);

        // full-length locked burst by A
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 3, 0, 1, 0, 0, 7, 0);
            @(negedge clk);
            check("burst_a_ready", a_ready, i < 4);
            check("burst_b_ready", b_ready, i == 4);
        end
        idle();

        // lock released early
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, i < 2, 3, 0, 1, 0, 0, 7, 0);
            @(negedge clk);
            check("early_a_ready", a_ready, i < 3);
            check("early_b_ready", b_ready, i == 3);
        end
        idle();

        // reset mid-burst
        drive(1, 0, 1, 3, 0, 1, 0, 0, 7, 0);
        @(negedge clk); check("mid_a_ready", a_ready, 1);
        @(posedge clk); #1;
        reset_n = 0; a_valid = 0; b_valid = 0; a_lock = 0;
        @(posedge clk); #1;
        reset_n = 1;
        @(negedge clk);
        check("rst_rsp_valid", a_rsp_valid, 0); check("rst_we", mem_write_en, 1);
        check("rst_addr", mem_address, 0); check("rst_data", mem_data_in, 0);
        check("rst_init_done", init_done, 0);
        repeat (20) idle();

        // randomized traffic, requests held while stalled
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            ha = a_valid && !a_ready;
            hb = b_valid && !b_ready;
            @(posedge clk); #1;
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 0; a_valid = 0; b_valid = 0;
                continue;
            end
            reset_n = 1;
            if (!ha) begin
                a_valid = $urandom_range(0, 3) != 0;
                a_write = 1'($urandom_range(0, 1));
                a_address = AW'($urandom_range(0, DEPTH - 1));
                a_data = DW'($urandom);
            end
            if (!hb) begin
                b_valid = $urandom_range(0, 3) != 0;
                b_write = 1'($urandom_range(0, 1));
                b_address = AW'($urandom_range(0, DEPTH - 1));
                b_data = DW'($urandom);
            end
            a_lock = $urandom_range(0, 2) == 0;
            b_lock = $urandom_range(0, 2) == 0;
        end
        reset_n = 1;
        repeat (3) idle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
